dcache_req_arbiter: RTL
=======================

DCACHE_REQ_ARBITER -- requirements
Module: dcache_req_arbiter

Interface
REQ-001 Parameter ADDR_W, 34, physical address width (riscv PLEN).
REQ-002 Parameter DATA_W, 32, data width (XLEN).
REQ-003 Parameter MAX_OUT, 2, maximum outstanding load reads (1..3).
REQ-004 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 Port flush_i  input  1  abandons any locked, ungranted request.
REQ-007 Ports ld_req_i (input, 1), ld_addr_i (input, ADDR_W), ld_be_i (input, DATA_W/8): load request; ld_gnt_o (output, 1): load grant.
REQ-008 Ports st_req_i (input, 1), st_addr_i (input, ADDR_W), st_wdata_i (input, DATA_W), st_be_i (input, DATA_W/8): store request; st_gnt_o (output, 1): store grant.
REQ-009 Ports req_o (output, 1), addr_o (output, ADDR_W), wdata_o (output, DATA_W), be_o (output, DATA_W/8), we_o (output, 1): shared cache request; gnt_i (input, 1): cache grant.
REQ-010 Ports rvalid_i (input, 1), rdata_i (input, DATA_W): cache read response; ld_rvalid_o (output, 1), ld_rdata_o (output, DATA_W): load response.
REQ-011 Ports st_done_o (output, 1): store accepted; idle_o (output, 1): nothing pending; err_o (output, 1): sticky protocol error.

Function
REQ-012 FSM states IDLE, LOCK_LD, LOCK_ST; LOCK_x means requester x is presented on req_o and not yet granted.
REQ-013 Load eligible = ld_req_i and registered count cnt_q < MAX_OUT; no same-cycle bypass from rvalid_i.
REQ-014 Store eligible = st_req_i.
REQ-015 IDLE, one eligible: select it combinationally; req_o asserted the same cycle (zero latency).
REQ-016 IDLE, both eligible: select load if rr_q=0, store if rr_q=1.
REQ-017 LOCK_x: select x regardless of the other requester or rr_q.
REQ-018 Mux: addr_o/be_o from the selected requester; wdata_o = st_wdata_i and we_o=1 if store selected, else wdata_o=0 and we_o=0; all zero when nothing selected.
REQ-019 ld_gnt_o = gnt_i and load selected; st_gnt_o = gnt_i and store selected; never both.
REQ-020 Selected and gnt_i=1: next state IDLE; rr_q <= 1 after a load grant, 0 after a store grant.
REQ-021 Selected and gnt_i=0: next state LOCK_LD or LOCK_ST; rr_q unchanged.
REQ-022 LOCK_x with x dropping its request, no flush_i: return to IDLE without grant; set err_o.
REQ-023 flush_i=1: next state IDLE; flush_i has no combinational effect, so a same-cycle gnt_i still completes; cnt_q and rr_q updated normally.
REQ-024 cnt_q: +1 on load grant, -1 on rvalid_i; both in the same cycle leaves it unchanged; width clog2(MAX_OUT+1).
REQ-025 rvalid_i with cnt_q=0: no decrement (no wrap); set err_o; ld_rvalid_o still forwarded.
REQ-026 ld_rvalid_o = rvalid_i, ld_rdata_o = rdata_i, combinational pass-through.
REQ-027 st_done_o registered: high exactly one cycle after each store grant.
REQ-028 idle_o = state IDLE and cnt_q=0 and req_o=0.
REQ-029 err_o, once set, holds until reset.

Reset
REQ-030 rst_ni=0 sampled at a clock edge: state IDLE, rr_q=0, cnt_q=0, st_done_o=0, err_o=0.
REQ-031 During reset, combinational outputs follow REQ-015..019 from the reset state, so requests may be presented; no state advances.
REQ-032 Reset mid-lock or with loads outstanding: lock and count dropped; responses arriving after reset set err_o per REQ-025.

Verification
REQ-033 Reset 2 cycles, ld_req_i=st_req_i=1, gnt_i=1 every cycle -> grants alternate ld, st, ld, st; st_done_o high the cycle after each st grant.
REQ-034 st_req_i=1, addr 0x0_1234_5678, gnt_i=0 for 3 cycles, ld_req_i raised in cycle 2 -> req_o held with we_o=1, addr_o=0x0_1234_5678 and no ld_gnt_o until the gnt_i cycle; then the load wins next.
REQ-035 MAX_OUT=2, two load grants, no rvalid_i -> third load not presented (req_o=0, idle_o=0); one rvalid_i -> load presented the next cycle.
REQ-036 cnt_q=1, load grant and rvalid_i in the same cycle -> cnt_q stays 1; two further rvalid_i -> second one sets err_o; cnt_q stays 0.
REQ-037 LOCK_ST, flush_i=1 with gnt_i=0 -> IDLE next cycle, no st_gnt_o, err_o=0; LOCK_ST with st_req_i dropped and no flush -> err_o=1.
REQ-038 Reset asserted in LOCK_LD with cnt_q=2 -> next cycle IDLE, cnt_q=0, idle_o=1, err_o=0.

Source files
------------

// File: rtl/dcache_req_arbiter.sv
// Arbitrates load and store requesters onto a single data-cache request port.
// A presented but ungranted request is locked until granted, dropped or flushed.
module dcache_req_arbiter #(
    parameter int ADDR_W  = 34,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                ld_req_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    input  logic [DATA_W/8-1:0] ld_be_i,
    output logic                ld_gnt_o,
    input  logic                st_req_i,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_wdata_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    output logic                st_gnt_o,
    output logic                req_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic                we_o,
    input  logic                gnt_i,
    input  logic                rvalid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic                ld_rvalid_o,
    output logic [DATA_W-1:0]   ld_rdata_o,
    output logic                st_done_o,
    output logic                idle_o,
    output logic                err_o,
    output logic [1:0]          state_o
);

    // Handshake: req_o stays high (locked) until gnt_i; a grant is a cycle with req_o && gnt_i.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_LD = 2'd1,
        LOCK_ST = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    state_t             state_q;
    logic               rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               st_done_q;
    logic               err_q;

    logic               ld_elig;
    logic               sel_ld;
    logic               sel_st;
    logic               dropped;
    logic               rv_ok;

    always_comb begin
        sel_ld  = 1'b0;
        sel_st  = 1'b0;
        ld_elig = ld_req_i && (cnt_q < CNT_W'(MAX_OUT));
        case (state_q)
            IDLE: begin
                if (ld_elig && st_req_i) begin
                    sel_ld = !rr_q;
                    sel_st = rr_q;
                end else begin
                    sel_ld = ld_elig;
                    sel_st = st_req_i;
                end
            end
            LOCK_LD: sel_ld = ld_req_i;
            LOCK_ST: sel_st = st_req_i;
            default: ;
        endcase
    end

    always_comb begin
        req_o   = sel_ld || sel_st;
        addr_o  = '0;
        be_o    = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        if (sel_ld) begin
            addr_o = ld_addr_i;
            be_o   = ld_be_i;
        end else if (sel_st) begin
            addr_o  = st_addr_i;
            be_o    = st_be_i;
            wdata_o = st_wdata_i;
            we_o    = 1'b1;
        end
    end

    assign ld_gnt_o    = gnt_i && sel_ld;
    assign st_gnt_o    = gnt_i && sel_st;
    assign ld_rvalid_o = rvalid_i;
    assign ld_rdata_o  = rdata_i;
    assign st_done_o   = st_done_q;
    assign err_o       = err_q;
    assign state_o     = state_q;
    assign idle_o      = (state_q == IDLE) && (cnt_q == '0) && !req_o;

    // A locked requester withdrawing is a protocol error unless a flush explains it.
    assign dropped = (state_q != IDLE) && !req_o;
    assign rv_ok   = rvalid_i && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            st_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            st_done_q <= st_gnt_o;
            if (ld_gnt_o && !rv_ok) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!ld_gnt_o && rv_ok) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (ld_gnt_o) begin
                rr_q <= 1'b1;
            end else if (st_gnt_o) begin
                rr_q <= 1'b0;
            end
            if ((rvalid_i && (cnt_q == '0)) || (dropped && !flush_i)) begin
                err_q <= 1'b1;
            end
            if (flush_i || !req_o || gnt_i) begin
                state_q <= IDLE;
            end else if (sel_ld) begin
                state_q <= LOCK_LD;
            end else begin
                state_q <= LOCK_ST;
            end
        end
    end

endmodule
